ascii_num_fmt: RTL and testbench
================================

Name: ascii_num_fmt

Overview:
Transmit-side counterpart of the ASCII number separator. On a start pulse it reads N signed integers from a synchronous-read RAM. It converts each one to decimal ASCII, separates them with single spaces, and streams the bytes out on a byte-wide valid/ready/last payload interface toward the UART packet transmitter. It is the formatter for results written back to the host.

Parameters:
DATA_WIDTH, 32, signed integer width in RAM (two's complement); conversion logic is sized for 32 only
DEPTH, 2048, RAM entries
ADDR_WIDTH, 11, RAM address width
MAX_DIGITS, 10, decimal digits needed for 2^31

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins formatting; ignored while busy
num_count  input  ADDR_WIDTH+1  number of entries to emit (0..DEPTH); sampled on start
rd_addr  output  ADDR_WIDTH  RAM read address
rd_data  input  DATA_WIDTH  RAM read data, valid 1 cycle after rd_addr
pkt_payload_data  output  8  ASCII byte
pkt_payload_valid  output  1  byte valid
pkt_payload_last  output  1  marks final byte of the packet
pkt_payload_ready  input  1  downstream accepts byte
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at completion

Behaviour:
- Reset (async, rst_n=0) values: pkt_payload_valid=0, pkt_payload_last=0, pkt_payload_data=0, rd_addr=0, busy=0, done=0, FSM=IDLE. Reset mid-operation aborts immediately. Partially sent packets are not completed.
- Handshake: a byte transfers on a rising edge with valid&&ready.
  - Once valid rises, data and last hold stable until the transfer.
  - valid never depends combinationally on ready.
  - At most one byte per cycle; back-to-back transfers allowed when ready stays high.
- Output format:
  - Decimal, no leading zeros; 0 emits "0".
  - Negative values are prefixed with '-' (0x2D).
  - Exactly one 0x20 between consecutive numbers; no leading or trailing space.
  - last=1 only on the final digit of entry num_count-1.
- Arithmetic:
  - Magnitude = rd_data[31] ? (~rd_data + 1) : rd_data, held as a 32-bit unsigned value, so -2147483648 gives 2147483648 exactly.
  - Digits are produced MSB-first by power-of-ten subtraction, k = 9 down to 0.
  - Each cycle, either subtract 10^k (digit count +1) when remainder >= 10^k, or commit the digit and decrement k.
  - Digits go into a MAX_DIGITS x 4-bit buffer. A leading-zero flag suppresses zeros until the first nonzero digit or k=0.
- FSM states:
  - IDLE: on start with num_count=0, pulse done next cycle and return to IDLE; no bytes sent. On start with num_count>0, latch the count, set idx=0, rd_addr=0, go to RD_WAIT.
  - RD_WAIT: one cycle for RAM latency; go to LATCH.
  - LATCH: capture sign and magnitude from rd_data; go to CONV.
  - CONV: subtract loop described above; after k=0 commits, go to EMIT_SIGN if negative, else EMIT_DIG.
  - EMIT_SIGN: present '-'; on transfer go to EMIT_DIG.
  - EMIT_DIG: present 0x30+digit for each stored significant digit in order; on the final digit transfer:
    - if idx==count-1, go to FIN;
    - else set idx+1 and rd_addr=idx+1, go to EMIT_SEP.
  - EMIT_SEP: present 0x20; on transfer go to RD_WAIT. The next read is already issued.
  - FIN: pulse done for 1 cycle, drop busy, return to IDLE.
- busy is high in every state except IDLE. start while busy is ignored.
- Latency per number: 2 cycles (RD_WAIT+LATCH), plus <= 10 + sum(digits) cycles of CONV, plus the output transfers.

Test Plan:
- RAM {123,456,789}, num_count=3, ready=1 -> bytes "123 456 789" (11 bytes); last only on final '9'; done pulses once; busy falls with done.
- RAM {-123,456,-789}, num_count=3 -> "-123 456 -789"; last on final '9'.
- RAM {2147483647,-2147483648}, num_count=2 -> "2147483647 -2147483648" (22 bytes); boundary magnitude correct.
- RAM {0,100,-1}, num_count=3, ready toggled 1-of-3 cycles -> "0 100 -1":
  - valid/data/last held stable while ready=0;
  - no byte lost or duplicated;
  - internal zeros in "100" not suppressed.
- num_count=0 start -> zero bytes, done pulse within 2 cycles. A second start pulse while busy during a 3-number run -> ignored, output unchanged.
- rst_n=0 asserted mid-stream during "123 456 789" -> valid=0 and busy=0 immediately. A fresh start afterwards -> full correct "123 456 789".

Source files
------------

// File: rtl/ascii_num_fmt.sv
// Streams N signed integers from a synchronous-read RAM as space-separated decimal ASCII.
// Digits come from power-of-ten subtraction, most significant first.
module ascii_num_fmt #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_count,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            pkt_payload_data,
    output logic                  pkt_payload_valid,
    output logic                  pkt_payload_last,
    input  logic                  pkt_payload_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DigW = $clog2(MAX_DIGITS + 1);
    localparam logic [ADDR_WIDTH:0] MaxCount = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StRdWait, StLatch, StConv, StEmitSign, StEmitDig, StEmitSep, StFin
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  neg_q, neg_d;
    logic [31:0]           rem_q, rem_d;
    logic [3:0]            k_q, k_d;
    logic [3:0]            dcnt_q, dcnt_d;
    logic [3:0]            digits_q [MAX_DIGITS];
    logic [3:0]            digits_d [MAX_DIGITS];
    logic [DigW-1:0]       ndig_q, ndig_d;
    logic [DigW-1:0]       ptr_q, ptr_d;
    logic                  lead_q, lead_d;

    logic [31:0] pow;
    logic        xfer;
    logic        last_dig;
    logic        last_num;

    function automatic logic [31:0] pow10(input logic [3:0] k);
        unique case (k)
            4'd0:    return 32'd1;
            4'd1:    return 32'd10;
            4'd2:    return 32'd100;
            4'd3:    return 32'd1000;
            4'd4:    return 32'd10000;
            4'd5:    return 32'd100000;
            4'd6:    return 32'd1000000;
            4'd7:    return 32'd10000000;
            4'd8:    return 32'd100000000;
            4'd9:    return 32'd1000000000;
            default: return 32'd1;
        endcase
    endfunction

    always_comb begin
        pow      = pow10(k_q);
        last_dig = (ptr_q == ndig_q - DigW'(1));
        last_num = (idx_q == count_q - (ADDR_WIDTH + 1)'(1));

        // Outputs are pure functions of registered state, so valid never sees ready.
        pkt_payload_valid = (state_q == StEmitSign) || (state_q == StEmitDig) ||
                            (state_q == StEmitSep);
        unique case (state_q)
            StEmitSign: pkt_payload_data = 8'h2D;
            StEmitDig:  pkt_payload_data = 8'h30 + {4'h0, digits_q[ptr_q]};
            StEmitSep:  pkt_payload_data = 8'h20;
            default:    pkt_payload_data = 8'h00;
        endcase
        pkt_payload_last = (state_q == StEmitDig) && last_dig && last_num;
        busy             = (state_q != StIdle);
        done             = (state_q == StFin);
        rd_addr          = addr_q;
        xfer             = pkt_payload_valid && pkt_payload_ready;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        neg_d    = neg_q;
        rem_d    = rem_q;
        k_d      = k_q;
        dcnt_d   = dcnt_q;
        digits_d = digits_q;
        ndig_d   = ndig_q;
        ptr_d    = ptr_q;
        lead_d   = lead_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_count == '0) begin
                        state_d = StFin;
                    end else begin
                        count_d = (num_count > MaxCount) ? MaxCount : num_count;
                        idx_d   = '0;
                        addr_d  = '0;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: state_d = StLatch;
            StLatch: begin
                neg_d   = rd_data[DATA_WIDTH-1];
                rem_d   = rd_data[DATA_WIDTH-1] ? (~rd_data + DATA_WIDTH'(1)) : rd_data;
                k_d     = 4'd9;
                dcnt_d  = '0;
                ndig_d  = '0;
                ptr_d   = '0;
                lead_d  = 1'b1;
                state_d = StConv;
            end
            StConv: begin
                if (rem_q >= pow) begin
                    rem_d  = rem_q - pow;
                    dcnt_d = dcnt_q + 4'd1;
                end else begin
                    // Leading zeros are dropped, but the units digit is always kept.
                    if (!(lead_q && dcnt_q == 4'd0 && k_q != 4'd0)) begin
                        digits_d[ndig_q] = dcnt_q;
                        ndig_d           = ndig_q + DigW'(1);
                        lead_d           = 1'b0;
                    end
                    dcnt_d = '0;
                    if (k_q == 4'd0) begin
                        state_d = neg_q ? StEmitSign : StEmitDig;
                    end else begin
                        k_d = k_q - 4'd1;
                    end
                end
            end
            StEmitSign: begin
                if (xfer) state_d = StEmitDig;
            end
            StEmitDig: begin
                if (xfer) begin
                    if (!last_dig) begin
                        ptr_d = ptr_q + DigW'(1);
                    end else if (last_num) begin
                        state_d = StFin;
                    end else begin
                        // Issue the next read now so it lands during the separator.
                        idx_d   = idx_q + (ADDR_WIDTH + 1)'(1);
                        addr_d  = idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                        state_d = StEmitSep;
                    end
                end
            end
            StEmitSep: begin
                if (xfer) state_d = StRdWait;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            neg_q   <= 1'b0;
            rem_q   <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            ndig_q  <= '0;
            ptr_q   <= '0;
            lead_q  <= 1'b1;
            for (int i = 0; i < MAX_DIGITS; i++) digits_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            neg_q    <= neg_d;
            rem_q    <= rem_d;
            k_q      <= k_d;
            dcnt_q   <= dcnt_d;
            ndig_q   <= ndig_d;
            ptr_q    <= ptr_d;
            lead_q   <= lead_d;
            digits_q <= digits_d;
        end
    end

endmodule

// File: tb/tb_ascii_num_fmt.sv
// Bench for ascii_num_fmt: table-driven packets, random packets against a $sformatf-based
// model, zero-count, start-while-busy and mid-stream reset sequences.
module tb_ascii_num_fmt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] num_count;
    logic [10:0] rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  pdata;
    logic        pvalid;
    logic        plast;
    logic        ready = 1'b0;
    logic        busy;
    logic        done;

    ascii_num_fmt dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_count         (num_count),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .pkt_payload_data  (pdata),
        .pkt_payload_valid (pvalid),
        .pkt_payload_last  (plast),
        .pkt_payload_ready (ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [2048];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int total = 0;
    int bad   = 0;
    int rmode = 0;
    int cyc   = 0;

    // Ready pattern: 0 always high, 1 high one cycle in three, 2 random.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rmode)
            0:       ready = 1'b1;
            1:       ready = (cyc % 3 == 0);
            default: ready = 1'($urandom % 2);
        endcase
    end

    byte unsigned got_q [$];
    bit           last_q [$];
    int           done_cnt  = 0;
    int           hold_viol = 0;
    bit           stall     = 1'b0;
    logic [7:0]   sd;
    logic         sl;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall && !(pvalid === 1'b1 && pdata === sd && plast === sl)) hold_viol++;
            if (pvalid && ready) begin
                got_q.push_back(pdata);
                last_q.push_back(plast);
            end
            stall = pvalid && !ready;
            sd    = pdata;
            sl    = plast;
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input longint g, input longint e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, g, e);
        end
    endtask

    function automatic string fmt_model(input int vals [$]);
        string s = "";
        foreach (vals[i]) begin
            if (i != 0) s = {s, " "};
            s = {s, $sformatf("%0d", vals[i])};
        end
        return s;
    endfunction

    function automatic int pick();
        int bnd [7];
        bnd = '{0, -1, 2147483647, int'(32'h8000_0000), 10, -10, 1000000000};
        case ($urandom % 4)
            0:       return int'($urandom % 21) - 10;
            1:       return int'($urandom);
            2:       return bnd[$urandom % 7];
            default: return -int'($urandom % 100000);
        endcase
    endfunction

    task automatic run_pkt(input int n, input int rm, input string exp, input bit dbl,
                           input string nm, output int lat);
        int    gb, db, hb, k, nl, lp;
        string gs;
        rmode = rm;
        gb    = got_q.size();
        db    = done_cnt;
        hb    = hold_viol;
        @(posedge clk); #2;
        num_count = 12'(n);
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
            if (dbl && k == 4) begin
                start     = 1'b1;
                num_count = 12'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        lat   = k;
        chk({nm, " done_seen"}, longint'(k < 4000), 1);
        repeat (2) @(negedge clk);
        gs = "";
        for (int i = gb; i < got_q.size(); i++) gs = {gs, $sformatf("%c", got_q[i])};
        total++;
        if (gs != exp) begin
            bad++;
            $display("FAIL %s bytes: got \"%s\" expected \"%s\"", nm, gs, exp);
        end
        nl = 0;
        lp = -1;
        for (int i = gb; i < last_q.size(); i++) begin
            if (last_q[i]) begin
                nl++;
                lp = i - gb;
            end
        end
        chk({nm, " last_count"}, nl, (exp.len() > 0) ? 1 : 0);
        if (exp.len() > 0) chk({nm, " last_pos"}, lp, exp.len() - 1);
        chk({nm, " done_pulses"}, done_cnt - db, 1);
        chk({nm, " busy_after"}, busy, 0);
        chk({nm, " hold_violations"}, hold_viol - hb, 0);
    endtask

    typedef struct {
        int    n;
        int    v0;
        int    v1;
        int    v2;
        int    rm;
        bit    dbl;
        string exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int    lat, gb, k, n;
        int    vals [$];
        string exp;

        tbl[0] = '{3, 123, 456, 789, 0, 1'b1, "123 456 789"};
        tbl[1] = '{3, -123, 456, -789, 0, 1'b0, "-123 456 -789"};
        tbl[2] = '{2, 2147483647, int'(32'h8000_0000), 0, 0, 1'b0, "2147483647 -2147483648"};
        tbl[3] = '{3, 0, 100, -1, 1, 1'b0, "0 100 -1"};

        rst_n     = 1'b0;
        start     = 1'b0;
        num_count = '0;
        repeat (3) @(negedge clk);
        chk("reset valid", pvalid, 0);
        chk("reset last", plast, 0);
        chk("reset data", pdata, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            mem[0] = tbl[t].v0;
            mem[1] = tbl[t].v1;
            mem[2] = tbl[t].v2;
            run_pkt(tbl[t].n, tbl[t].rm, tbl[t].exp, tbl[t].dbl, $sformatf("vec%0d", t), lat);
        end

        run_pkt(0, 0, "", 1'b0, "zero_count", lat);
        chk("zero_count latency_le_2", longint'(lat <= 2), 1);

        for (int t = 0; t < 8; t++) begin
            n = 1 + int'($urandom % 6);
            vals.delete();
            for (int i = 0; i < n; i++) begin
                vals.push_back(pick());
                mem[i] = vals[i];
            end
            exp = fmt_model(vals);
            run_pkt(n, 2, exp, 1'b0, $sformatf("rand%0d", t), lat);
        end

        // Abort mid-packet, then confirm a clean restart.
        mem[0] = 123;
        mem[1] = 456;
        mem[2] = 789;
        rmode  = 0;
        gb     = got_q.size();
        @(posedge clk); #2;
        num_count = 12'd3;
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        k = 0;
        while (got_q.size() - gb < 5 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("midrst reached_bytes", longint'(k < 300), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", pvalid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_pkt(3, 0, "123 456 789", 1'b0, "after_rst", lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
